random_delay_timer: RTL
=======================

# random_delay_timer

Downstream consumer of the 4-bit LFSR random number. On a start pulse it samples `randomNumber` and converts it into a pseudo-random wait of `BASE_TICKS + randomNumber*STEP_TICKS` ticks, where one tick is `TICK_DIV` clock cycles. When the wait expires it emits a one-cycle `timeUp` pulse. Game/reaction-timer control logic uses it as the "random wait before stimulus" stage.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per tick (1 ms at 50 MHz); must be ≥ 1.
- `BASE_TICKS`, default 500: fixed minimum delay in ticks.
- `STEP_TICKS`, default 100: ticks added per LSB of the random number.
- `CNT_W`, default 12: tick counter width. Requires `BASE_TICKS + 15*STEP_TICKS < 2^CNT_W`.

Ports:
- `clock`, input, 1: single system clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new delay; sampled only in IDLE.
- `cancel`, input, 1: abort the current delay.
- `randomNumber`, input, 4: value from the LFSR, sampled on an accepted start.
- `busy`, output, 1: high while a delay is in progress (COUNT or DONE).
- `timeUp`, output, 1: one-cycle pulse when the delay expires.
- `capturedValue`, output, 4: `randomNumber` as latched at the last accepted start.

## Operation
- FSM states are IDLE, COUNT and DONE. All outputs are registered.
- Reset (`reset`=0) forces state=IDLE, `busy`=0, `timeUp`=0, `capturedValue`=0, tick counter=0, prescaler=0. This applies immediately, including mid-count; no `timeUp` is produced for an interrupted delay.
- IDLE:
  - If `start`=1 and `cancel`=0: latch `capturedValue` ← `randomNumber`, load N = `BASE_TICKS` + `randomNumber`*`STEP_TICKS` (computed at `CNT_W` bits, no overflow by the parameter rule), clear the prescaler, go to COUNT.
  - If `start`=1 and `cancel`=1: cancel wins and the FSM stays in IDLE.
- COUNT:
  - The prescaler counts 0..`TICK_DIV`-1, then wraps. Each wrap decrements the tick counter.
  - When the counter would reach 0, go to DONE.
  - If N=0 was loaded, go to DONE on the next edge without prescaling.
  - `cancel`=1 goes to IDLE and clears the counter and prescaler; it has priority over expiry in the same cycle.
  - `start` is ignored (no retrigger).
- DONE: `timeUp`=1 for exactly this cycle, then go to IDLE unconditionally. `start` and `cancel` are ignored here.
- `capturedValue` holds its value until the next accepted start.

## Timing
- Let edge k be the edge that accepts `start`.
  - `busy`=1 from k through the DONE cycle.
  - `busy`=0 after the edge that leaves DONE.
- Latency:
  - N≥1: `timeUp` is high in the cycle following edge k + N*`TICK_DIV`.
  - N=0: `timeUp` is high in the cycle following edge k+1.
- The earliest next accepted start is the first edge after the `timeUp` cycle, so the minimum start-to-start spacing is latency+1.
- Cancel: a `cancel` sampled at edge c gives `busy`=0 after c, with no `timeUp`.

## Structure
- Shared package/include:
  - state encodings (IDLE=2'd0, COUNT=2'd1, DONE=2'd2; 2'd3 decodes to IDLE);
  - default parameter constants;
  - the delay-computation function.
- Sub-module `tick_prescaler`:
  - parameter `TICK_DIV`; inputs `clock`, `reset`, `clear`, `enable`; output `tick` (one-cycle pulse on wrap);
  - same asynchronous active-low reset.
- The top level holds the FSM, the `capturedValue` register and the tick counter.

## Test plan
All scenarios use `TICK_DIV`=4, `BASE_TICKS`=2, `STEP_TICKS`=1.
- Start with `randomNumber`=5 (N=7) -> `busy` rises after edge k, `timeUp` is a single pulse after edge k+28, `capturedValue`=5.
- Start with `randomNumber`=0 (N=2) -> `timeUp` after edge k+8; with `BASE_TICKS`=0 instead, `timeUp` after edge k+1.
- `cancel` asserted 10 cycles into a delay -> `busy`=0 next cycle, no `timeUp`; a subsequent start with `randomNumber`=3 gives `timeUp` after 20 cycles.
- `start` pulsed repeatedly during COUNT and during the DONE cycle -> ignored, original expiry unchanged; a start on the first IDLE cycle is accepted.
- `reset` driven low mid-count -> all outputs 0 immediately; after release, IDLE with no spurious `timeUp`.
- `start` and `cancel` together in IDLE -> stays IDLE, `busy`=0, `capturedValue` unchanged.

Source files
------------

// File: rtl/random_delay_timer_pkg.sv
// Shared definitions for random_delay_timer: FSM state encoding, default
// parameter values and the random-number-to-delay conversion.
package random_delay_timer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefTickDiv   = 50000;
  localparam int unsigned DefBaseTicks = 500;
  localparam int unsigned DefStepTicks = 100;
  localparam int unsigned DefCntW      = 12;

  // Wait length in ticks for a given 4-bit random value.
  function automatic int unsigned calc_delay(int unsigned base, int unsigned step,
                                             logic [3:0] rnd);
    return base + 32'(rnd) * step;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into ticks: counts 0..TICK_DIV-1 while enabled and
// flags the wrap cycle with a one-cycle tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] Last = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  assign tick = enable && !clear && (cnt_q == Last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/random_delay_timer.sv
// Pseudo-random wait timer: samples a 4-bit random value on start, waits
// BASE_TICKS + value*STEP_TICKS ticks and then pulses timeUp for one cycle.
module random_delay_timer
  import random_delay_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DefTickDiv,
  parameter int unsigned BASE_TICKS = DefBaseTicks,
  parameter int unsigned STEP_TICKS = DefStepTicks,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic [3:0] randomNumber,
  output logic       busy,
  output logic       timeUp,
  output logic [3:0] capturedValue
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             time_up_q;
  logic [3:0]       captured_q;
  logic             tick;
  logic             pre_clear;
  logic             pre_enable;

  // Prescaler only runs while counting; it is held clear everywhere else,
  // so a freshly accepted start always begins from a zero phase.
  assign pre_enable = (state_q == StCount);
  assign pre_clear  = (state_q != StCount) || cancel;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (pre_clear),
    .enable(pre_enable),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      time_up_q  <= 1'b0;
      captured_q <= '0;
    end else begin
      time_up_q <= 1'b0;
      case (state_q)
        StCount: begin
          if (cancel) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            // Zero-length delay: expire on the first edge, no prescaling.
            state_q   <= StDone;
            time_up_q <= 1'b1;
          end else if (tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q   <= StDone;
              time_up_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          // Idle; the unused encoding also lands here.
          state_q <= StIdle;
          if (start && !cancel) begin
            state_q    <= StCount;
            captured_q <= randomNumber;
            cnt_q      <= CNT_W'(calc_delay(BASE_TICKS, STEP_TICKS, randomNumber));
            busy_q     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign timeUp        = time_up_q;
  assign capturedValue = captured_q;

endmodule
